// File: rtl/cam_arbiter.sv
// Round-robin arbiter that shares one CAM among NUM_REQ requesters, one op at a time.
// Optional per-requester grant and search-miss counters when CAM_ARBITER_STATS_EN is defined.
module cam_arbiter #(
    parameter int unsigned NUM_REQ          = 2,
    parameter int unsigned ARRAY_WIDTH_LOG2 = 5,
    parameter int unsigned ARRAY_SIZE_LOG2  = 5,
    localparam int unsigned DW = 1 << ARRAY_WIDTH_LOG2,
    localparam int unsigned IW = ARRAY_SIZE_LOG2
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [2*NUM_REQ-1:0]    req_op_i,
    input  logic [IW*NUM_REQ-1:0]   req_index_i,
    input  logic [DW*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic                    rsp_hit_o,
    output logic [DW-1:0]           rsp_data_o,
    output logic [IW-1:0]           rsp_index_o,
    output logic                    cam_read_o,
    output logic                    cam_write_o,
    output logic                    cam_search_o,
    output logic [IW-1:0]           cam_index_o,
    output logic [DW-1:0]           cam_data_o,
    input  logic                    cam_read_valid_i,
    input  logic [DW-1:0]           cam_read_value_i,
    input  logic                    cam_search_valid_i,
    input  logic [IW-1:0]           cam_search_index_i
`ifdef CAM_ARBITER_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]   grant_cnt_o,
    output logic [15:0]             miss_cnt_o
`endif
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_q;
    logic            found;
    logic [1:0]      op_q;
    int unsigned     cand;

    logic [1:0]      op_arr  [NUM_REQ];
    logic [IW-1:0]   idx_arr [NUM_REQ];
    logic [DW-1:0]   dat_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g]  = req_op_i[2*g +: 2];
        assign idx_arr[g] = req_index_i[IW*g +: IW];
        assign dat_arr[g] = req_data_i[DW*g +: DW];
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin : rr_pick
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid_i[PW'(cand)]) begin
                found = 1'b1;
                win   = PW'(cand);
            end
        end
    end

    assign req_ready_o = (state == S_IDLE && found) ? (NUM_REQ'(1) << win) : '0;

`ifdef CAM_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign grant_cnt_o[16*g +: 16] = grant_cnt[g];
    end
`endif

    always_ff @(posedge clk or posedge reset_i) begin : fsm
        if (reset_i) begin
            state        <= S_IDLE;
            ptr          <= '0;
            win_q        <= '0;
            op_q         <= '0;
            cam_read_o   <= 1'b0;
            cam_write_o  <= 1'b0;
            cam_search_o <= 1'b0;
            cam_index_o  <= '0;
            cam_data_o   <= '0;
            rsp_valid_o  <= '0;
            rsp_hit_o    <= 1'b0;
            rsp_data_o   <= '0;
            rsp_index_o  <= '0;
`ifdef CAM_ARBITER_STATS_EN
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
            miss_cnt_o <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state        <= S_ISSUE;
                        win_q        <= win;
                        op_q         <= op_arr[win];
                        cam_read_o   <= (op_arr[win] == OP_READ);
                        cam_write_o  <= (op_arr[win] == OP_WRITE);
                        cam_search_o <= (op_arr[win] == OP_SEARCH);
                        cam_index_o  <= idx_arr[win];
                        cam_data_o   <= dat_arr[win];
                        ptr          <= (32'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
`ifdef CAM_ARBITER_STATS_EN
                        if (grant_cnt[win] != 16'hFFFF) grant_cnt[win] <= grant_cnt[win] + 16'd1;
`endif
                    end
                end
                S_ISSUE: begin
                    cam_read_o   <= 1'b0;
                    cam_write_o  <= 1'b0;
                    cam_search_o <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    // CAM result is valid during this cycle; capture it for the response.
                    state       <= S_RESP;
                    rsp_valid_o <= NUM_REQ'(1) << win_q;
                    rsp_hit_o   <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_index_o <= '0;
                    case (op_q)
                        OP_READ: begin
                            rsp_hit_o  <= cam_read_valid_i;
                            rsp_data_o <= cam_read_value_i;
                        end
                        OP_WRITE:  rsp_hit_o <= 1'b1;
                        OP_SEARCH: begin
                            rsp_hit_o   <= cam_search_valid_i;
                            rsp_index_o <= cam_search_valid_i ? cam_search_index_i : '0;
                        end
                        default: ;
                    endcase
`ifdef CAM_ARBITER_STATS_EN
                    if (op_q == OP_SEARCH && !cam_search_valid_i && miss_cnt_o != 16'hFFFF)
                        miss_cnt_o <= miss_cnt_o + 16'd1;
`endif
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    rsp_valid_o <= '0;
                    rsp_hit_o   <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_index_o <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_arbiter.sv
// Bench for cam_arbiter: a behavioural CAM drives the cam_* inputs; a scoreboard predicts grants,
// strobes and responses from the arbitration rules and a separate monitor compares them.
module tb_cam_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned PW = 1;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_i;
    logic [NR-1:0]        req_valid_i, req_ready_o, rsp_valid_o;
    logic [NR-1:0][1:0]   op_d;
    logic [NR-1:0][IW-1:0] idx_d;
    logic [NR-1:0][DW-1:0] dat_d;
    logic                 rsp_hit_o;
    logic [DW-1:0]        rsp_data_o, cam_data_o, cam_read_value_i;
    logic [IW-1:0]        rsp_index_o, cam_index_o, cam_search_index_i;
    logic                 cam_read_o, cam_write_o, cam_search_o, cam_read_valid_i, cam_search_valid_i;
`ifdef CAM_ARBITER_STATS_EN
    logic [16*NR-1:0]     grant_cnt_o;
    logic [15:0]          miss_cnt_o;
`endif

    cam_arbiter #(.NUM_REQ(NR), .ARRAY_WIDTH_LOG2(5), .ARRAY_SIZE_LOG2(5)) dut (
        .clk(clk), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(op_d), .req_index_i(idx_d), .req_data_i(dat_d),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o), .rsp_index_o(rsp_index_o),
        .cam_read_o(cam_read_o), .cam_write_o(cam_write_o), .cam_search_o(cam_search_o),
        .cam_index_o(cam_index_o), .cam_data_o(cam_data_o),
        .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
        .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
`ifdef CAM_ARBITER_STATS_EN
        , .grant_cnt_o(grant_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural CAM: registered results one cycle after a strobe, lowest index wins a search.
    logic        ev [32];
    logic [31:0] ed [32];
    always @(posedge clk) begin
        cam_read_valid_i   <= 1'b0;
        cam_read_value_i   <= '0;
        cam_search_valid_i <= 1'b0;
        cam_search_index_i <= '0;
        if (cam_read_o) begin
            cam_read_valid_i <= ev[cam_index_o];
            cam_read_value_i <= ev[cam_index_o] ? ed[cam_index_o] : 32'h0;
        end
        if (cam_write_o) begin
            ev[cam_index_o] <= 1'b1;
            ed[cam_index_o] <= cam_data_o;
        end
        if (cam_search_o)
            for (int j = 31; j >= 0; j--)
                if (ev[j] && ed[j] == cam_data_o) begin
                    cam_search_valid_i <= 1'b1;
                    cam_search_index_i <= 5'(j);
                end
    end

    typedef struct { int w; logic hit; logic [31:0] data; logic [4:0] idx; int cyc; logic miss; } rsp_t;
    typedef struct { logic [2:0] strb; logic [4:0] idx; logic [31:0] data; logic ci; logic cd; int cyc; } stb_t;
    rsp_t rq[$];
    stb_t sq[$];
    int   grants[$];

    // Reference model state: stored entries, round-robin pointer, busy window.
    logic        rv [32];
    logic [31:0] rd [32];
    int          ptr_m   = 0;
    int          last_hs = -100;
    int          miss_m  = 0;

    // Scoreboard: predict ready, and on a handshake push the expected strobe and response.
    always @(negedge clk) begin : scoreboard
        int w, c;
        logic [NR-1:0] exp_rdy;
        logic [1:0] op;
        logic [4:0] ix;
        logic [31:0] d;
        rsp_t e;
        stb_t s;
        if (!reset_i) begin
            w = -1;
            if (cyc >= last_hs + 4)
                for (int k = 0; k < NR; k++) begin
                    c = (ptr_m + k) % NR;
                    if (w < 0 && req_valid_i[PW'(c)]) w = c;
                end
            exp_rdy = (w >= 0) ? (NR'(1) << w) : '0;
            chk("ready", 64'(req_ready_o), 64'(exp_rdy));
            if (w >= 0) begin
                op = op_d[PW'(w)]; ix = idx_d[PW'(w)]; d = dat_d[PW'(w)];
                e.w = w; e.cyc = cyc + 3; e.hit = 1'b0; e.data = '0; e.idx = '0; e.miss = 1'b0;
                s.cyc = cyc + 1; s.idx = ix; s.data = d; s.ci = 1'b0; s.cd = 1'b0; s.strb = 3'b000;
                case (op)
                    2'b00: begin e.hit = rv[ix]; e.data = rv[ix] ? rd[ix] : 32'h0; s.strb = 3'b100; s.ci = 1'b1; end
                    2'b01: begin rv[ix] = 1'b1; rd[ix] = d; e.hit = 1'b1; s.strb = 3'b010; s.ci = 1'b1; s.cd = 1'b1; end
                    2'b10: begin
                        for (int j = 31; j >= 0; j--)
                            if (rv[j] && rd[j] == d) begin e.hit = 1'b1; e.idx = 5'(j); end
                        e.miss = !e.hit; s.strb = 3'b001; s.cd = 1'b1;
                    end
                    default: ;
                endcase
                rq.push_back(e);
                if (s.strb != 3'b000) sq.push_back(s);
                grants.push_back(w);
                last_hs = cyc;
                ptr_m = (w + 1) % NR;
            end
        end
    end

    // Monitor: compare strobes and responses whenever the DUT presents them.
    always @(negedge clk) begin : monitor
        rsp_t e;
        stb_t es;
        logic [2:0] s3;
        if (!reset_i) begin
            s3 = {cam_read_o, cam_write_o, cam_search_o};
            if (sq.size() > 0 && sq[0].cyc < cyc) begin
                chk("strobe_missing", 64'(cyc), 64'(sq[0].cyc));
                void'(sq.pop_front());
            end
            if (s3 != 3'b000) begin
                if (sq.size() == 0) chk("strobe_unexpected", 64'(s3), 64'(0));
                else begin
                    es = sq.pop_front();
                    chk("strobe_kind", 64'(s3), 64'(es.strb));
                    if (es.ci) chk("cam_index", 64'(cam_index_o), 64'(es.idx));
                    if (es.cd) chk("cam_data", 64'(cam_data_o), 64'(es.data));
                    chk("strobe_cycle", 64'(cyc), 64'(es.cyc));
                end
            end
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rsp_missing", 64'(cyc), 64'(rq[0].cyc));
                void'(rq.pop_front());
            end
            if (rsp_valid_o != '0) begin
                if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid_o), 64'(0));
                else begin
                    e = rq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid_o), 64'(NR'(1) << e.w));
                    chk("rsp_hit", 64'(rsp_hit_o), 64'(e.hit));
                    chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
                    chk("rsp_index", 64'(rsp_index_o), 64'(e.idx));
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
`ifdef CAM_ARBITER_STATS_EN
                    if (e.miss) miss_m++;
                    chk("miss_cnt", 64'(miss_cnt_o), 64'(miss_m));
`endif
                end
            end else
                chk("rsp_idle_bus", {26'h0, rsp_hit_o, rsp_data_o, rsp_index_o}, 64'(0));
        end
    end

    // Raise a request and hold it until granted or until limit cycles pass; call at posedge+1.
    task automatic issue(input int r, input logic [1:0] op, input logic [4:0] ix, input logic [31:0] d,
                         input int limit, output bit granted);
        op_d[PW'(r)] = op; idx_d[PW'(r)] = ix; dat_d[PW'(r)] = d;
        req_valid_i[PW'(r)] = 1'b1;
        granted = 1'b0;
        for (int k = 0; k < limit && !granted; k++) begin
            @(negedge clk);
            if (req_ready_o[PW'(r)]) granted = 1'b1;
        end
        @(posedge clk); #1;
        req_valid_i[PW'(r)] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output int n, output logic hit, output logic [31:0] d,
                            output logic [4:0] ix, output logic [2:0] so);
        n = 0; hit = 1'b0; d = '0; ix = '0; so = '0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            @(negedge clk);
            so |= {cam_read_o, cam_write_o, cam_search_o};
            if (rsp_valid_o[PW'(r)]) begin
                n = k + 1; hit = rsp_hit_o; d = rsp_data_o; ix = rsp_index_o;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic directed(input string nm, input int r, input logic [1:0] op, input logic [4:0] ix,
                            input logic [31:0] d, input logic hit_e, input logic [31:0] d_e, input logic [4:0] ix_e);
        bit g; int n; logic h; logic [31:0] rdv; logic [4:0] ri; logic [2:0] so;
        issue(r, op, ix, d, 50, g);
        chk({nm, "_grant"}, 64'(g), 64'(1));
        wait_rsp(r, n, h, rdv, ri, so);
        chk({nm, "_latency"}, 64'(n), 64'(3));
        chk({nm, "_hit"}, 64'(h), 64'(hit_e));
        chk({nm, "_data"}, 64'(rdv), 64'(d_e));
        chk({nm, "_index"}, 64'(ri), 64'(ix_e));
        if (op == 2'b11) chk({nm, "_no_strobe"}, 64'(so), 64'(0));
    endtask

    task automatic stream(input int r, input int n_ops, input logic [4:0] base);
        bit g;
        for (int i = 0; i < n_ops; i++) issue(r, 2'b00, base + 5'(i), 32'h0, 50, g);
    endtask

    task automatic rand_req(input int r);
        bit g; int gap, lim;
        repeat (25) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 60;
            issue(r, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 32'($urandom_range(1, 6)), lim, g);
        end
    endtask

    task automatic flush_model();
        rq.delete(); sq.delete();
        last_hs = -100; ptr_m = 0; miss_m = 0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin : main
        bit g;
        int g0;
        for (int j = 0; j < 32; j++) begin ev[j] = 1'b0; rv[j] = 1'b0; ed[j] = '0; rd[j] = '0; end
        reset_i = 1'b1; req_valid_i = '0; op_d = '0; idx_d = '0; dat_d = '0;
        #1;
        chk("reset_ready", 64'(req_ready_o), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("reset_strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'(0));
        chk("reset_cam_bus", {27'h0, cam_index_o, cam_data_o}, 64'(0));
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Reset during the strobe cycle kills the op.
        issue(0, 2'b00, 5'd3, 32'h0, 50, g);
        chk("t1_grant", 64'(g), 64'(1));
        chk("t1_strobe_up", 64'(cam_read_o), 64'(1));
        #2 reset_i = 1'b1;
        #1;
        chk("t1_strobe_drop", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'(0));
        chk("t1_rsp_drop", 64'(rsp_valid_o), 64'(0));
        flush_model();
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t1_no_rsp", 64'(rsp_valid_o), 64'(0));
        end
        @(posedge clk); #1;

        directed("t2_write", 0, 2'b01, 5'd5, 32'h5, 1'b1, 32'h0, 5'd0);
        directed("t2_read",  0, 2'b00, 5'd5, 32'h0, 1'b1, 32'h5, 5'd0);
        directed("t3_search_hit",  0, 2'b10, 5'd0, 32'h5, 1'b1, 32'h0, 5'd5);
        directed("t3_search_miss", 0, 2'b10, 5'd0, 32'h9, 1'b0, 32'h0, 5'd0);
`ifdef CAM_ARBITER_STATS_EN
        chk("t3_miss_cnt", 64'(miss_cnt_o), 64'(1));
`endif
        directed("t5_illegal", 1, 2'b11, 5'd7, 32'hDEAD, 1'b0, 32'h0, 5'd0);

        // Two continuous requesters must alternate.
        g0 = grants.size();
        fork
            stream(0, 3, 5'd20);
            stream(1, 3, 5'd24);
        join
        repeat (6) begin @(posedge clk); #1; end
        chk("t4_grant_count", 64'(grants.size() - g0), 64'(6));
        for (int i = 0; i < 6 && g0 + i < grants.size(); i++)
            chk("t4_grant_order", 64'(grants[g0 + i]), 64'(i % 2));

        directed("t6_read_unwritten", 0, 2'b00, 5'd4, 32'h0, 1'b0, 32'h0, 5'd0);

        fork
            rand_req(0);
            rand_req(1);
        join
        repeat (10) begin @(posedge clk); #1; end
        chk("drain_rsp_queue", 64'(rq.size()), 64'(0));
        chk("drain_strobe_queue", 64'(sq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
